nco_table_loader: RTL and testbench
===================================

// Module: nco_table_loader
// PURPOSE
//  Upstream loader for the NCO counter. Takes a valid/ready word stream and writes it into
//  the counter's two sine-table write ports: bank 0 (csb00/addr00/din00) first, then bank 1
//  (csb01/addr01/din01). Latches and holds the num/denum frequency ratio for the counter.
//  This is the hardware replacement for bench-driven table initialisation.
// PARAMETERS
//  DATA_W   16  sine sample width (din0x, s_data)
//  ADDR_W   8   table address width; each bank depth is 2**ADDR_W = 256
//  RATIO_W  4   width of num/denum
// PORTS
//  clk       in   1        system clock, rising-edge
//  rst       in   1        reset, asynchronous, active-low
//  start     in   1        one-cycle load request; latches num_in/denum_in
//  abort     in   1        synchronous cancel of a load in progress
//  num_in    in   RATIO_W  requested numerator
//  denum_in  in   RATIO_W  requested denominator
//  s_valid   in   1        stream word valid
//  s_data    in   DATA_W   stream word: bank 0 words 0..255, then bank 1 words 0..255
//  s_ready   out  1        loader accepts s_data this cycle
//  csb00     out  1        bank 0 write strobe, active-low
//  addr00    out  ADDR_W   bank 0 write address
//  din00     out  DATA_W   bank 0 write data
//  csb01     out  1        bank 1 write strobe, active-low
//  addr01    out  ADDR_W   bank 1 write address
//  din01     out  DATA_W   bank 1 write data
//  num       out  RATIO_W  latched numerator to the counter
//  denum     out  RATIO_W  latched denominator to the counter
//  busy      out  1        load in progress
//  done      out  1        one-cycle pulse: both banks fully written
//  err       out  1        one-cycle pulse: start rejected
// BEHAVIOUR
//  - All outputs are registered. Reset values: csb00=csb01=1, addr0x=0, din0x=0, s_ready=0,
//    busy=0, done=0, err=0, num=1, denum=1. The state machine resets to IDLE.
//  - FSM states: IDLE, LOAD0, LOAD1. The word counter wcnt is ADDR_W bits.
//  - IDLE: s_ready=0. A start is valid when num_in!=0, denum_in!=0 and num_in<=denum_in.
//    - Valid start: latch num/denum, set wcnt=0, go to LOAD0, busy=1 from the next cycle.
//    - Invalid start: err=1 for one cycle; stay in IDLE; num/denum unchanged.
//  - LOAD0/LOAD1: s_ready=1. A handshake is s_valid&s_ready. A handshake in cycle t makes
//    the active bank's csb=0 in t+1, with addr=wcnt(t) and din=s_data(t); then wcnt++.
//    - Write latency is 1 cycle. csb is high in every cycle that does not follow a handshake.
//    - Addresses are strictly contiguous; gaps on s_valid create no duplicate writes.
//  - Handshake with wcnt=255: in LOAD0, wcnt wraps to 0 and the FSM goes to LOAD1. In LOAD1,
//    the FSM goes to IDLE, and s_ready=0 from the next cycle.
//  - done=1 in the same cycle as the final csb01 strobe (addr01=255); busy=0 in that cycle.
//  - start while busy: ignored, with no err pulse.
//  - abort: takes priority over any handshake in the same cycle; that word is not written.
//    Next cycle: IDLE, csb0x=1, busy=0, no done. num/denum keep the latched values.
//    Partially written table contents are unspecified.
//  - abort and start in the same IDLE cycle: abort wins, and start is ignored.
//  - rst asserted mid-load: all outputs take reset values immediately. The next valid start
//    restarts at bank 0, addr 0.
//  - addr0x/din0x hold their last values while csb is high.
// CONFIGURATION
//  NCO_LDR_CHECKSUM_EN defined:
//    - Adds input chk_in[DATA_W-1:0], latched on a valid start, and output chk_err.
//    - A running sum (mod 2**DATA_W) covers all 512 accepted words.
//    - chk_err updates in the done cycle: 1 if sum!=chk_in, else 0.
//    - chk_err holds until the next valid start clears it. abort leaves it unchanged.
//  Not defined: no chk_in/chk_err ports and no sum logic; the behaviour above is otherwise identical.
// TESTING
//  1 Reset: hold rst=0 mid-run -> csb00=csb01=1, addr/din=0, s_ready=busy=done=err=0, num=denum=1.
//  2 start num=2 denum=3, s_valid=1 always, s_data=i for i=0..511 -> 256 csb00 strobes at
//    addr00 0..255 with din00 0..255, then 256 csb01 strobes at addr01 0..255 with din01
//    256..511; done pulses once with the addr01=255 write; num=2, denum=3.
//  3 s_valid toggling 1,0,1,0 -> one csb strobe per accepted word, contiguous addresses,
//    512 writes total, done after the 512th.
//  4 start with num_in=0, and again with num_in=5 denum_in=3 -> err 1-cycle pulse each time;
//    s_ready stays 0; num/denum stay at prior values.
//  5 Pull rst low after 100 bank-0 words, release, start again -> first write is csb00 at
//    addr00=0. abort after 300 words -> IDLE next cycle, no done.
//  6 (NCO_LDR_CHECKSUM_EN) data 0..511 with chk_in=16'hFF00 -> chk_err=0; same data with
//    chk_in=16'hFF01 -> chk_err=1 at done, held until next start.

Source files
------------

// File: rtl/nco_table_loader.sv
// Streams 512 sine samples into the NCO counter's two table write ports and holds num/denum.
// Optional NCO_LDR_CHECKSUM_EN adds chk_in/chk_err comparison of the running word sum.
module nco_table_loader #(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 8,
    parameter int RATIO_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    input  logic [RATIO_W-1:0] num_in,
    input  logic [RATIO_W-1:0] denum_in,
    input  logic               s_valid,
    input  logic [DATA_W-1:0]  s_data,
    output logic               s_ready,
    output logic               csb00,
    output logic [ADDR_W-1:0]  addr00,
    output logic [DATA_W-1:0]  din00,
    output logic               csb01,
    output logic [ADDR_W-1:0]  addr01,
    output logic [DATA_W-1:0]  din01,
    output logic [RATIO_W-1:0] num,
    output logic [RATIO_W-1:0] denum,
    output logic               busy,
    output logic               done,
    output logic               err
`ifdef NCO_LDR_CHECKSUM_EN
    ,
    input  logic [DATA_W-1:0]  chk_in,
    output logic               chk_err
`endif
);

    typedef enum logic [1:0] {IDLE, LOAD0, LOAD1} state_t;

    state_t              state, state_nx;
    logic [ADDR_W-1:0]   wcnt, wcnt_nx;
    logic                s_ready_nx, busy_nx, done_nx, err_nx;
    logic                csb00_nx, csb01_nx;
    logic [ADDR_W-1:0]   addr00_nx, addr01_nx;
    logic [DATA_W-1:0]   din00_nx, din01_nx;
    logic [RATIO_W-1:0]  num_nx, denum_nx;
    logic                hs, last, start_ok;
`ifdef NCO_LDR_CHECKSUM_EN
    logic [DATA_W-1:0]   sum, sum_nx, chk, chk_nx;
    logic                chk_err_nx;
`endif

    assign hs       = s_valid & s_ready;
    assign last     = (wcnt == '1);
    assign start_ok = (num_in != '0) && (denum_in != '0) && (num_in <= denum_in);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            wcnt    <= '0;
            s_ready <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
            csb00   <= 1'b1;
            csb01   <= 1'b1;
            addr00  <= '0;
            addr01  <= '0;
            din00   <= '0;
            din01   <= '0;
            num     <= RATIO_W'(1);
            denum   <= RATIO_W'(1);
`ifdef NCO_LDR_CHECKSUM_EN
            sum     <= '0;
            chk     <= '0;
            chk_err <= 1'b0;
`endif
        end else begin
            state   <= state_nx;
            wcnt    <= wcnt_nx;
            s_ready <= s_ready_nx;
            busy    <= busy_nx;
            done    <= done_nx;
            err     <= err_nx;
            csb00   <= csb00_nx;
            csb01   <= csb01_nx;
            addr00  <= addr00_nx;
            addr01  <= addr01_nx;
            din00   <= din00_nx;
            din01   <= din01_nx;
            num     <= num_nx;
            denum   <= denum_nx;
`ifdef NCO_LDR_CHECKSUM_EN
            sum     <= sum_nx;
            chk     <= chk_nx;
            chk_err <= chk_err_nx;
`endif
        end
    end

    always_comb begin
        state_nx  = state;
        wcnt_nx   = wcnt;
        csb00_nx  = 1'b1;
        csb01_nx  = 1'b1;
        addr00_nx = addr00;
        addr01_nx = addr01;
        din00_nx  = din00;
        din01_nx  = din01;
        num_nx    = num;
        denum_nx  = denum;
        done_nx   = 1'b0;
        err_nx    = 1'b0;
`ifdef NCO_LDR_CHECKSUM_EN
        sum_nx     = sum;
        chk_nx     = chk;
        chk_err_nx = chk_err;
`endif
        case (state)
            IDLE: begin
                // abort in the same cycle suppresses both the load and the err pulse
                if (start && !abort) begin
                    if (start_ok) begin
                        num_nx   = num_in;
                        denum_nx = denum_in;
                        wcnt_nx  = '0;
                        state_nx = LOAD0;
`ifdef NCO_LDR_CHECKSUM_EN
                        sum_nx     = '0;
                        chk_nx     = chk_in;
                        chk_err_nx = 1'b0;
`endif
                    end else begin
                        err_nx = 1'b1;
                    end
                end
            end
            LOAD0, LOAD1: begin
                if (abort) begin
                    state_nx = IDLE;
                end else if (hs) begin
                    wcnt_nx = wcnt + ADDR_W'(1);
`ifdef NCO_LDR_CHECKSUM_EN
                    sum_nx = sum + s_data;
`endif
                    if (state == LOAD0) begin
                        csb00_nx  = 1'b0;
                        addr00_nx = wcnt;
                        din00_nx  = s_data;
                        if (last) state_nx = LOAD1;
                    end else begin
                        csb01_nx  = 1'b0;
                        addr01_nx = wcnt;
                        din01_nx  = s_data;
                        if (last) begin
                            state_nx = IDLE;
                            done_nx  = 1'b1;
`ifdef NCO_LDR_CHECKSUM_EN
                            chk_err_nx = ((sum + s_data) != chk);
`endif
                        end
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
        s_ready_nx = (state_nx != IDLE);
        busy_nx    = (state_nx != IDLE);
    end

endmodule

// File: tb/tb_nco_table_loader.sv
// Scoreboard bench for nco_table_loader; checksum checks run when NCO_LDR_CHECKSUM_EN is defined.
module tb_nco_table_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0, abort = 1'b0;
    logic [3:0]  num_in = 4'd0, denum_in = 4'd0;
    logic        s_valid = 1'b0;
    logic [15:0] s_data = '0;
    logic        s_ready, csb00, csb01, busy, done, err;
    logic [7:0]  addr00, addr01;
    logic [15:0] din00, din01;
    logic [3:0]  num, denum;
`ifdef NCO_LDR_CHECKSUM_EN
    logic [15:0] chk_in = '0;
    logic        chk_err;
`endif

    nco_table_loader #(.DATA_W(16), .ADDR_W(8), .RATIO_W(4)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .num_in(num_in), .denum_in(denum_in),
        .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .csb00(csb00), .addr00(addr00), .din00(din00),
        .csb01(csb01), .addr01(addr01), .din01(din01),
        .num(num), .denum(denum), .busy(busy), .done(done), .err(err)
`ifdef NCO_LDR_CHECKSUM_EN
        , .chk_in(chk_in), .chk_err(chk_err)
`endif
    );

    always #5 clk = ~clk;

    // kind: 0 = bank0 write, 1 = bank1 write, 2 = err pulse, 3 = stray done
    typedef struct {
        int kind;
        int addr;
        int data;
        bit done;
    } exp_t;

    exp_t        q[$];
    logic [15:0] words[512];
    int          total = 0;
    int          passed = 0;

    task automatic check(input string nm, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    always @(negedge clk) begin
        if (rst && (!csb00 || !csb01 || err || done)) begin
            exp_t e;
            int   k, a, d;
            k = !csb00 ? 0 : (!csb01 ? 1 : (err ? 2 : 3));
            a = (k == 0) ? int'(addr00) : ((k == 1) ? int'(addr01) : 0);
            d = (k == 0) ? int'(din00) : ((k == 1) ? int'(din01) : 0);
            total++;
            if (!csb00 && !csb01) begin
                $display("FAIL dual_strobe: both banks strobed at addr %0d/%0d", addr00, addr01);
            end else if (q.size() == 0) begin
                $display("FAIL unexpected_event: got kind %0d addr %0d data %0d done %0d, expected none",
                         k, a, d, done);
            end else begin
                e = q.pop_front();
                if (e.kind == k && e.addr == a && e.data == d && e.done == done)
                    passed++;
                else
                    $display("FAIL sb_event: got kind %0d addr %0d data %0d done %0d, expected kind %0d addr %0d data %0d done %0d",
                             k, a, d, done, e.kind, e.addr, e.data, e.done);
            end
        end
    end

    task automatic push_writes(input int n);
        for (int i = 0; i < n; i++)
            q.push_back('{kind: (i < 256) ? 0 : 1, addr: i % 256, data: int'(words[i]), done: (i == 511)});
    endtask

    task automatic push_err();
        q.push_back('{kind: 2, addr: 0, data: 0, done: 1'b0});
    endtask

    // drives one start pulse; returns at posedge+1 after it was sampled
    task automatic do_start(input int n, input int d, input int c);
        @(posedge clk); #1;
        start = 1'b1; num_in = 4'(n); denum_in = 4'(d);
`ifdef NCO_LDR_CHECKSUM_EN
        chk_in = 16'(c);
`else
        if (c < 0) $display("negative checksum value ignored");
`endif
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // streams words[0..n-1]; gap inserts an idle cycle after each word; inject pulses start while busy
    task automatic stream(input int n, input bit gap, input bit inject);
        for (int i = 0; i < n; i++) begin
            check("s_ready_in_load", int'(s_ready), 1);
            s_valid = 1'b1;
            s_data  = words[i];
            if (inject && i == 10) begin start = 1'b1; num_in = 4'd0; denum_in = 4'd1; end
            if (inject && i == 20) begin start = 1'b1; num_in = 4'd1; denum_in = 4'd2; end
            @(posedge clk); #1;
            start = 1'b0;
            if (gap && i < n - 1) begin
                s_valid = 1'b0;
                s_data  = 16'hDEAD;
                @(posedge clk); #1;
            end
        end
        s_valid = 1'b0;
    endtask

    task automatic drain(input string nm);
        repeat (4) @(posedge clk);
        #1;
        check(nm, q.size(), 0);
        q.delete();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk);
        check("rst_csb00", int'(csb00), 1);
        check("rst_csb01", int'(csb01), 1);
        check("rst_s_ready", int'(s_ready), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_num", int'(num), 1);
        check("rst_denum", int'(denum), 1);
        @(posedge clk); #1;
        rst = 1'b1;

        // full load, continuous valid, data 0..511
        for (int i = 0; i < 512; i++) words[i] = 16'(i);
        do_start(2, 3, 16'hFF00);
        check("t2_busy_start", int'(busy), 1);
        push_writes(512);
        stream(512, 1'b0, 1'b0);
        check("t2_busy_done_cycle", int'(busy), 0);
        check("t2_done_cycle", int'(done), 1);
        check("t2_num", int'(num), 2);
        check("t2_denum", int'(denum), 3);
`ifdef NCO_LDR_CHECKSUM_EN
        check("t6_chk_err_match", int'(chk_err), 0);
`endif
        drain("t2_drain");
        check("t2_ready_idle", int'(s_ready), 0);

        // toggling valid, num==denum boundary, start while busy ignored
        do_start(3, 3, 16'hFF01);
        push_writes(512);
        stream(512, 1'b1, 1'b1);
        check("t3_busy_done_cycle", int'(busy), 0);
`ifdef NCO_LDR_CHECKSUM_EN
        check("t6_chk_err_mismatch", int'(chk_err), 1);
`endif
        drain("t3_drain");
        check("t3_num", int'(num), 3);
        check("t3_denum", int'(denum), 3);

        // invalid starts
        push_err();
        do_start(0, 5, 0);
        check("t4_ready_a", int'(s_ready), 0);
        check("t4_busy_a", int'(busy), 0);
        push_err();
        do_start(5, 3, 0);
        check("t4_ready_b", int'(s_ready), 0);
        push_err();
        do_start(2, 0, 0);
        drain("t4_drain");
        check("t4_num", int'(num), 3);
        check("t4_denum", int'(denum), 3);
`ifdef NCO_LDR_CHECKSUM_EN
        check("t6_chk_err_held", int'(chk_err), 1);
        do_start(1, 2, 0);
        check("t6_chk_err_cleared", int'(chk_err), 0);
        @(posedge clk); #1;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        check("t6_abort_busy", int'(busy), 0);
`endif

        // reset mid-load after 100 bank-0 words
        for (int i = 0; i < 512; i++) words[i] = 16'hA000 + 16'(i * 3);
        do_start(4, 8, 0);
        push_writes(100);
        stream(100, 1'b0, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        check("t5_rst_csb00", int'(csb00), 1);
        check("t5_rst_addr00", int'(addr00), 0);
        check("t5_rst_din00", int'(din00), 0);
        check("t5_rst_addr01", int'(addr01), 0);
        check("t5_rst_din01", int'(din01), 0);
        check("t5_rst_ready", int'(s_ready), 0);
        check("t5_rst_busy", int'(busy), 0);
        check("t5_rst_num", int'(num), 1);
        check("t5_rst_denum", int'(denum), 1);
        check("t5_pre_rst_writes", q.size(), 0);
        @(posedge clk); #1;
        rst = 1'b1;

        // restart at bank 0 addr 0, abort after 300 words
        do_start(5, 7, 0);
        push_writes(300);
        stream(300, 1'b0, 1'b0);
        abort = 1'b1; s_valid = 1'b1; s_data = 16'h5555;
        @(posedge clk); #1;
        abort = 1'b0; s_valid = 1'b0;
        check("t5_abort_busy", int'(busy), 0);
        check("t5_abort_ready", int'(s_ready), 0);
        check("t5_abort_num", int'(num), 5);
        check("t5_abort_denum", int'(denum), 7);
        drain("t5_abort_drain");

        // abort and valid start together in IDLE
        @(posedge clk); #1;
        abort = 1'b1; start = 1'b1; num_in = 4'd1; denum_in = 4'd1;
        @(posedge clk); #1;
        abort = 1'b0; start = 1'b0;
        check("t5_abort_start_busy", int'(busy), 0);
        check("t5_abort_start_num", int'(num), 5);
        drain("t5_final_drain");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
